// File: rtl/petersen_pkg.sv
// Shared constants, state encoding and the fixed Petersen graph tables
// (vertex pixel coordinates and the 15-entry edge list).
package petersen_pkg;

  localparam int COORD_W  = 9;
  localparam int VIDX_W   = 4;
  localparam int EIDX_W   = 4;
  localparam int NUM_VERT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ORDER,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_FIN
  } state_t;

  // First vertex of an edge: outer pentagon, spokes, then inner pentagram
  function automatic logic [VIDX_W-1:0] edgeVa(input logic [EIDX_W-1:0] e);
    case (e)
      4'd0:  edgeVa = 4'd0;
      4'd1:  edgeVa = 4'd1;
      4'd2:  edgeVa = 4'd2;
      4'd3:  edgeVa = 4'd3;
      4'd4:  edgeVa = 4'd4;
      4'd5:  edgeVa = 4'd0;
      4'd6:  edgeVa = 4'd1;
      4'd7:  edgeVa = 4'd2;
      4'd8:  edgeVa = 4'd3;
      4'd9:  edgeVa = 4'd4;
      4'd10: edgeVa = 4'd5;
      4'd11: edgeVa = 4'd7;
      4'd12: edgeVa = 4'd9;
      4'd13: edgeVa = 4'd6;
      4'd14: edgeVa = 4'd8;
      default: edgeVa = 4'd0;
    endcase
  endfunction

  // Second vertex of an edge
  function automatic logic [VIDX_W-1:0] edgeVb(input logic [EIDX_W-1:0] e);
    case (e)
      4'd0:  edgeVb = 4'd1;
      4'd1:  edgeVb = 4'd2;
      4'd2:  edgeVb = 4'd3;
      4'd3:  edgeVb = 4'd4;
      4'd4:  edgeVb = 4'd0;
      4'd5:  edgeVb = 4'd5;
      4'd6:  edgeVb = 4'd6;
      4'd7:  edgeVb = 4'd7;
      4'd8:  edgeVb = 4'd8;
      4'd9:  edgeVb = 4'd9;
      4'd10: edgeVb = 4'd7;
      4'd11: edgeVb = 4'd9;
      4'd12: edgeVb = 4'd6;
      4'd13: edgeVb = 4'd8;
      4'd14: edgeVb = 4'd5;
      default: edgeVb = 4'd0;
    endcase
  endfunction

  // Vertex x coordinate in pixels
  function automatic logic [COORD_W-1:0] vertexX(input logic [VIDX_W-1:0] v);
    case (v)
      4'd0: vertexX = 9'd120;
      4'd1: vertexX = 9'd215;
      4'd2: vertexX = 9'd179;
      4'd3: vertexX = 9'd61;
      4'd4: vertexX = 9'd25;
      4'd5: vertexX = 9'd120;
      4'd6: vertexX = 9'd168;
      4'd7: vertexX = 9'd149;
      4'd8: vertexX = 9'd91;
      4'd9: vertexX = 9'd72;
      default: vertexX = 9'd0;
    endcase
  endfunction

  // Vertex y coordinate in pixels
  function automatic logic [COORD_W-1:0] vertexY(input logic [VIDX_W-1:0] v);
    case (v)
      4'd0: vertexY = 9'd60;
      4'd1: vertexY = 9'd129;
      4'd2: vertexY = 9'd241;
      4'd3: vertexY = 9'd241;
      4'd4: vertexY = 9'd129;
      4'd5: vertexY = 9'd110;
      4'd6: vertexY = 9'd145;
      4'd7: vertexY = 9'd200;
      4'd8: vertexY = 9'd200;
      4'd9: vertexY = 9'd145;
      default: vertexY = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/petersen_rom.sv
// Pure combinational lookup from edge index to the two endpoint
// coordinates, in edge-table order (no ordering applied here).
module petersen_rom
  import petersen_pkg::*;
(
  input  logic [EIDX_W-1:0]  edgeSel_i,
  output logic [COORD_W-1:0] xa_o,
  output logic [COORD_W-1:0] ya_o,
  output logic [COORD_W-1:0] xb_o,
  output logic [COORD_W-1:0] yb_o
);

  logic [VIDX_W-1:0] va;
  logic [VIDX_W-1:0] vb;

  // Resolve the edge to its vertices, then the vertices to pixels
  always_comb begin
    va   = edgeVa(edgeSel_i);
    vb   = edgeVb(edgeSel_i);
    xa_o = vertexX(va);
    ya_o = vertexY(va);
    xb_o = vertexX(vb);
    yb_o = vertexY(vb);
  end

endmodule

// File: rtl/petersen_edge_sequencer.sv
// Walks the Petersen edge table, orders each edge so x1 <= x2, and hands
// it to the line stage with a start/done handshake plus a settle gap.
module petersen_edge_sequencer
  import petersen_pkg::*;
#(
  parameter int NUM_EDGES  = 15,
  parameter int GAP_CYCLES = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_line_done,
  output logic               o_line_start,
  output logic [COORD_W-1:0] o_x1,
  output logic [COORD_W-1:0] o_y1,
  output logic [COORD_W-1:0] o_x2,
  output logic [COORD_W-1:0] o_y2,
  output logic [EIDX_W-1:0]  o_edge_idx,
  output logic               o_busy,
  output logic               o_done
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [EIDX_W-1:0] EDGE_LAST = EIDX_W'(NUM_EDGES - 1);

  state_t             state_q, state_d;
  logic [EIDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               busy_q, busy_d;
  logic [COORD_W-1:0] xa_q, ya_q, xb_q, yb_q;
  logic [COORD_W-1:0] xa_d, ya_d, xb_d, yb_d;
  logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q;
  logic [COORD_W-1:0] x1_d, y1_d, x2_d, y2_d;
  logic [COORD_W-1:0] romXa, romYa, romXb, romYb;

  petersen_rom u_rom (
    .edgeSel_i (idx_q),
    .xa_o      (romXa),
    .ya_o      (romYa),
    .xb_o      (romXb),
    .yb_o      (romYb)
  );

  // State and datapath registers; reset abandons any run in progress
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      xa_q    <= '0;
      ya_q    <= '0;
      xb_q    <= '0;
      yb_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      xb_q    <= xb_d;
      yb_q    <= yb_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
    end
  end

  // Next-state logic: fetch, order, issue, wait for done, settle, repeat
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    xb_d    = xb_q;
    yb_d    = yb_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x2_d    = x2_q;
    y2_d    = y2_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_FETCH;
          busy_d  = 1'b1;
          idx_d   = '0;
        end
      end
      ST_FETCH: begin
        xa_d    = romXa;
        ya_d    = romYa;
        xb_d    = romXb;
        yb_d    = romYb;
        state_d = ST_ORDER;
      end
      ST_ORDER: begin
        if (xa_q > xb_q) begin
          x1_d = xb_q;
          y1_d = yb_q;
          x2_d = xa_q;
          y2_d = ya_q;
        end else begin
          x1_d = xa_q;
          y1_d = ya_q;
          x2_d = xb_q;
          y2_d = yb_q;
        end
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_line_done) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (idx_q == EDGE_LAST) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_FETCH;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_line_start = (state_q == ST_ISSUE);
  assign o_done       = (state_q == ST_FIN);
  assign o_busy       = busy_q;
  assign o_edge_idx   = idx_q;
  assign o_x1         = x1_q;
  assign o_y1         = y1_q;
  assign o_x2         = x2_q;
  assign o_y2         = y2_q;

endmodule

// File: doc/petersen_edge_sequencer.md
Name: petersen_edge_sequencer

Overview:
- Upstream feeder for the SPI line-drawing stage.
- Walks a fixed 15-edge table over a fixed 10-vertex table (the Petersen graph) and resolves each edge to pixel endpoints.
- Orders each edge's endpoints so that x1 <= x2, because the line stage only steps x upward.
- Presents each line with a one-cycle start pulse, waits for the line stage's done pulse, then advances to the next edge.

Parameters:
- NUM_EDGES, 15, number of edge-table entries walked per run
- GAP_CYCLES, 16, idle cycles after each line-done before the next fetch (lets the line stage settle in its idle state)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  level/pulse; begins a run when sampled high in IDLE
- i_line_done  in  1  one-cycle done pulse from the line stage
- o_line_start  out  1  one-cycle start pulse to the line stage
- o_x1  out  9  line start x, always <= o_x2
- o_y1  out  9  line start y
- o_x2  out  9  line end x
- o_y2  out  9  line end y
- o_edge_idx  out  4  index of the edge currently issued, 0..14
- o_busy  out  1  high from run acceptance until o_done
- o_done  out  1  one-cycle pulse after the last edge's line-done

Behaviour:
- Reset (synchronous, i_rst high at a clock edge) forces:
  - state IDLE
  - o_line_start = 0, o_busy = 0, o_done = 0
  - o_edge_idx = 0, all coordinate outputs = 0, gap counter = 0
- Reset mid-run abandons the run immediately. No done pulse is produced.
- States: IDLE, FETCH, ORDER, ISSUE, WAIT, GAP, FIN.
- IDLE:
  - i_start high -> FETCH, o_busy <= 1, edge index <= 0.
  - i_start is ignored in every other state.
- FETCH: read edge (va, vb) from the edge table, then read both vertex coordinates. Combinational ROM lookup, registered into internal regs.
- ORDER:
  - If xa > xb, swap the endpoints; otherwise keep them.
  - Equal x keeps table order; vertical edges are passed through unmodified.
  - Register the result onto o_x1/o_y1/o_x2/o_y2 -> ISSUE.
- ISSUE: o_line_start = 1 for exactly this one cycle -> WAIT.
- Coordinate hold: coordinates are valid in the ISSUE cycle and held stable through WAIT and GAP.
- Latency: the start pulse occurs exactly 3 cycles after the cycle in which i_start is sampled (FETCH, ORDER, ISSUE).
- WAIT:
  - Hold until i_line_done = 1.
  - i_line_done outside WAIT is ignored, including a done arriving in the same cycle as ISSUE.
  - On done: gap counter <= 0 -> GAP.
- GAP:
  - Count GAP_CYCLES cycles.
  - At expiry, if edge index == NUM_EDGES-1 -> FIN; else increment the edge index -> FETCH.
- FIN: o_done = 1 for one cycle, o_busy <= 0 -> IDLE. Coordinate outputs retain the last edge.
- No timeout: a missing i_line_done stalls in WAIT indefinitely. Only reset recovers.
- Widths:
  - Coordinates are unsigned 9-bit, within range 0..319.
  - Edge index is 4-bit and never exceeds 14.
  - The gap counter is sized by clog2(GAP_CYCLES+1).

Decomposition:
- Shared package `petersen_pkg` holds:
  - vertex table (x,y), 10 entries:
    - v0 (120,60), v1 (215,129), v2 (179,241), v3 (61,241), v4 (25,129)
    - v5 (120,110), v6 (168,145), v7 (149,200), v8 (91,200), v9 (72,145)
  - edge table, 15 entries in this order:
    - 0-1, 1-2, 2-3, 3-4, 4-0
    - 0-5, 1-6, 2-7, 3-8, 4-9
    - 5-7, 7-9, 9-6, 6-8, 8-5
  - coordinate width constant (9), vertex index width (4), state encoding.
- One sub-module is natural: `petersen_rom`. It is a pure combinational edge-index -> (xa,ya,xb,yb) lookup. The sequencer FSM owns ordering and handshake.

Test Plan:
- Reset, then pulse i_start -> o_line_start high 3 cycles later with x1=120, y1=60, x2=215, y2=129, o_edge_idx=0, o_busy=1.
- Edge 3 (v3-v4) -> swapped: x1=25, y1=129, x2=61, y2=241.
- Edge 5 (v0-v5, vertical) -> x1=x2=120, y1=60, y2=110, no swap.
- Model the line stage with done 40 cycles after start -> 15 start pulses, each next start exactly GAP_CYCLES+3 cycles after the previous done. o_done pulses once, GAP_CYCLES+1 cycles after the 15th done. o_busy falls with it.
- Spurious i_line_done in GAP, plus i_start held high throughout -> no extra starts, no edge skipped, no run restart until IDLE.
- Assert i_rst while in WAIT on edge 7 -> next cycle all outputs zero, state IDLE. A following i_start restarts at edge 0.
